// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 cipher core, one round per clock.
// Encrypt or inverse cipher on a pre-expanded key schedule.
module aes_cipher_iter #(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   decrypt,
  input  logic [127:0]           data_in,
  input  logic [128*(NR+1)-1:0]  expanded_keys,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           data_out,
  output logic                   busy
);

  localparam int CW = $clog2(NR + 1);
  localparam logic [CW-1:0] NR_C = CW'(NR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic            mode_q, mode_d;
  logic [127:0]    rk [NR+1];
  logic [CW-1:0]   rk_idx;
  logic [127:0]    rk_sel;
  logic            last;
  logic [127:0]    t, m, round_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // One shared inverter serves both S-box directions
  function automatic logic [7:0] sub_byte(input logic [7:0] b,
                                          input logic inv);
    logic [7:0] x, y;
    x = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^
               {b[1:0], b[7:2]} ^ 8'h05) : b;
    y = gf_inv(x);
    if (!inv)
      y = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^
          {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    return y;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s,
                                             input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8], inv);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                              input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s,
                                            input logic inv);
    logic [7:0]   k [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(k[(j + 4 - r) % 4],
                             s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = expanded_keys[(NR+1)*128-1-r*128 -: 128];
  end

  assign rk_idx = mode_q ? NR_C - cnt_q : cnt_q;
  assign rk_sel = rk[rk_idx];
  assign last   = (cnt_q == NR_C);

  // One round of the selected direction; final round skips mixing
  always_comb begin
    t = sub_bytes(shift_rows(data_q, mode_q), mode_q);
    m = mix_cols(mode_q ? t ^ rk_sel : t, mode_q);
    if (last)        round_out = t ^ rk_sel;
    else if (mode_q) round_out = m;
    else             round_out = m ^ rk_sel;
  end

  // Next state: accept in IDLE, iterate in RUN, hand off in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d   = CW'(1);
        mode_d  = decrypt;
        data_d  = data_in ^ (decrypt ? rk[NR] : rk[0]);
      end
      RUN: begin
        data_d = round_out;
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round counter, mode and data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: AES-128/192/256 instances checked
// against a table-driven FIPS-197 model and known-answer vectors.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         decrypt [3];
  logic [127:0] data_in [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] data_out [3];
  logic         busy [3];
  logic [1407:0] ek4;
  logic [1663:0] ek6;
  logic [1919:0] ek8;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  int           m_phase [3];
  int           m_left [3];
  logic [127:0] m_res [3];
  logic [127:0] m_data [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_iter #(.NK(4)) u_aes4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .decrypt(decrypt[0]), .data_in(data_in[0]),
    .expanded_keys(ek4),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .data_out(data_out[0]), .busy(busy[0])
  );

  aes_cipher_iter #(.NK(6)) u_aes6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .decrypt(decrypt[1]), .data_in(data_in[1]),
    .expanded_keys(ek6),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .data_out(data_out[1]), .busy(busy[1])
  );

  aes_cipher_iter #(.NK(8)) u_aes8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .decrypt(decrypt[2]), .data_in(data_in[2]),
    .expanded_keys(ek8),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .data_out(data_out[2]), .busy(busy[2])
  );

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  function automatic int nr_of(input int i);
    return 10 + 2 * i;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] q, input int n);
    return (q << n) | (q >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic void expand(input int nk, input logic [255:0] key,
                                 output logic [127:0] rk [15]);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endfunction

  function automatic logic [127:0] t_sub(input logic [127:0] x,
                                         input logic inv);
    for (int i = 0; i < 16; i++)
      x[127-8*i -: 8] = inv ? isb[x[127-8*i -: 8]] : sb[x[127-8*i -: 8]];
    return x;
  endfunction

  function automatic logic [127:0] t_shift(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] t_mix(input logic [127:0] x);
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] y;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = xt(a0 ^ a1) ^ a1 ^ a2 ^ a3;
      y[119-32*c -: 8] = xt(a1 ^ a2) ^ a2 ^ a3 ^ a0;
      y[111-32*c -: 8] = xt(a2 ^ a3) ^ a3 ^ a0 ^ a1;
      y[103-32*c -: 8] = xt(a3 ^ a0) ^ a0 ^ a1 ^ a2;
    end
    return y;
  endfunction

  function automatic logic [127:0] aes_model(input int nk,
                                             input logic [255:0] key,
                                             input logic dec,
                                             input logic [127:0] blk);
    logic [127:0] rk [15];
    logic [127:0] s;
    int nr;
    nr = nk + 6;
    expand(nk, key, rk);
    if (!dec) begin
      s = blk ^ rk[0];
      for (int r = 1; r <= nr; r++) begin
        s = t_shift(t_sub(s, 1'b0));
        if (r < nr) s = t_mix(s);
        s = s ^ rk[r];
      end
    end else begin
      s = blk ^ rk[nr];
      for (int r = nr - 1; r >= 0; r--) begin
        s = t_sub(t_shift(t_shift(t_shift(s))), 1'b1) ^ rk[r];
        if (r > 0) s = t_mix(t_mix(t_mix(s)));
      end
    end
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_phase[i] <= 0;
        m_left[i]  <= 0;
        m_res[i]   <= '0;
        m_data[i]  <= '0;
      end else if (m_phase[i] == 0) begin
        if (in_valid[i]) begin
          m_phase[i] <= 1;
          m_left[i]  <= nr_of(i);
          m_res[i]   <= aes_model(4 + 2 * i, KEY, decrypt[i], data_in[i]);
        end
      end else if (m_phase[i] == 1) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_phase[i] <= 2;
          m_data[i]  <= m_res[i];
        end
      end else if (out_ready[i]) begin
        m_phase[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d in_ready", i),
              128'(in_ready[i]), 128'(m_phase[i] == 0));
        check($sformatf("u%0d out_valid", i),
              128'(out_valid[i]), 128'(m_phase[i] == 2));
        check($sformatf("u%0d busy", i),
              128'(busy[i]), 128'(m_phase[i] != 0));
        if (m_phase[i] != 1)
          check($sformatf("u%0d data_out", i), data_out[i], m_data[i]);
      end
    end
  end

  task automatic run_block(input int i, input logic dec,
                           input logic [127:0] din,
                           input logic [127:0] exp, input int hold,
                           input logic early, input string nm);
    int n;
    @(negedge clk);
    in_valid[i] = 1'b1;
    decrypt[i]  = dec;
    data_in[i]  = din;
    n = 0;
    while (!in_ready[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " accept"}, 128'(in_ready[i]), 128'd1);
    @(negedge clk);
    in_valid[i]  = 1'b0;
    decrypt[i]   = ~dec;
    data_in[i]   = ~din;
    out_ready[i] = early;
    n = 1;
    while (!out_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 128'(n), 128'(nr_of(i) + 1));
    check({nm, " data"}, data_out[i], exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, " hold data"}, data_out[i], exp);
      check({nm, " hold in_ready"}, 128'(in_ready[i]), 128'd0);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    check({nm, " ready after"}, 128'(in_ready[i]), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]   p, q;
    logic [127:0] rks [15];
    int n, t, prev;

    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      decrypt[i]   = 1'b0;
      data_in[i]   = '0;
      out_ready[i] = 1'b0;
    end

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    expand(4, KEY, rks);
    for (int r = 0; r <= 10; r++) ek4[1407-128*r -: 128] = rks[r];
    expand(6, KEY, rks);
    for (int r = 0; r <= 12; r++) ek6[1663-128*r -: 128] = rks[r];
    expand(8, KEY, rks);
    for (int r = 0; r <= 14; r++) ek8[1919-128*r -: 128] = rks[r];

    check("model C.1 enc", aes_model(4, KEY, 1'b0, PT), CT4);
    check("model C.2 enc", aes_model(6, KEY, 1'b0, PT), CT6);
    check("model C.3 enc", aes_model(8, KEY, 1'b0, PT), CT8);
    check("model C.3 dec", aes_model(8, KEY, 1'b1, CT8), PT);

    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset u%0d in_ready", i), 128'(in_ready[i]), 128'd1);
      check($sformatf("reset u%0d out_valid", i), 128'(out_valid[i]), 128'd0);
      check($sformatf("reset u%0d busy", i), 128'(busy[i]), 128'd0);
      check($sformatf("reset u%0d data_out", i), data_out[i], 128'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_block(0, 1'b0, PT, CT4, 0, 1'b0, "C.1 enc");
    run_block(1, 1'b0, PT, CT6, 0, 1'b1, "C.2 enc");
    run_block(2, 1'b0, PT, CT8, 0, 1'b0, "C.3 enc");
    run_block(2, 1'b1, CT8, PT, 0, 1'b0, "C.3 dec");
    run_block(0, 1'b0, PT, CT4, 20, 1'b0, "backpressure");

    @(negedge clk);
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      decrypt[0] = (k % 2 == 1);
      data_in[0] = (k % 2 == 1) ? CT4 : PT;
      n = 0;
      while (!in_ready[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      t = cyc;
      if (k > 0) check("b2b spacing", 128'(t - prev), 128'd12);
      prev = t;
      @(negedge clk);
      n = 0;
      while (!out_valid[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b out_valid", 128'(out_valid[0]), 128'd1);
      check("b2b data", data_out[0], (k % 2 == 1) ? PT : CT4);
      if (k == 3) in_valid[0] = 1'b0;
    end
    @(negedge clk);
    out_ready[0] = 1'b0;

    @(negedge clk);
    check("rst start ready", 128'(in_ready[0]), 128'd1);
    in_valid[0] = 1'b1;
    decrypt[0]  = 1'b0;
    data_in[0]  = PT;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("rst mid busy", 128'(busy[0]), 128'd1);
    #2 reset = 1'b1;
    #1;
    check("rst mid out_valid", 128'(out_valid[0]), 128'd0);
    check("rst mid in_ready", 128'(in_ready[0]), 128'd1);
    check("rst mid data_out", data_out[0], 128'd0);
    check("rst mid busy low", 128'(busy[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    run_block(0, 1'b0, PT, CT4, 0, 1'b0, "C.1 after reset");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
